// File: rtl/anc_pkg.sv
// Shared types and constants for the ANC sample loop.
// Pure declarations, no logic.
// Imported by the sequencer and by the cup plant model.
package anc_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLANT_REQ  = 3'd1,
        PLANT_WAIT = 3'd2,
        FILT_REQ   = 3'd3,
        FILT_WAIT  = 3'd4,
        UPDATE     = 3'd5
    } seq_state_t;

    localparam logic [7:0] DEFAULT_DELAY = 8'd64;
    localparam logic [7:0] DEFAULT_SCALE = 8'd128;

endpackage

// File: rtl/anc_sample_sequencer_wait_timer.sv
// Wait-state watchdog: counts cycles since the last clear.
// tc_o is high combinationally once the count equals TIMEOUT_CYCLES-1.
// No handshake; the counter holds at terminal count until cleared.
module wait_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q;

    assign tc_o = (cnt_q == TC_VAL);

    // Clear takes priority so each wait state starts counting from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/anc_sample_sequencer.sv
// Per-sample ANC sequencer: plant request, plant wait, filter request, filter wait, update.
// Latency: strobe in cycle T gives sample_valid_out in T+5 when both done inputs come on their first wait cycle.
// No backpressure: strobes arriving while busy are dropped and counted as overruns.
module anc_sample_sequencer
    import anc_pkg::*;
#(
    parameter logic [7:0] DELAY_RESET    = DEFAULT_DELAY,
    parameter logic [7:0] SCALE_RESET    = DEFAULT_SCALE,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter int         CNT_W          = 16
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             sample_strobe_in,
    input  sample_t          ambient_sample_in,
    input  logic [7:0]       cfg_delay_in,
    input  logic [7:0]       cfg_scale_in,
    input  logic             cfg_load_in,
    output logic             plant_ready_out,
    output sample_t          plant_ambient_out,
    output sample_t          plant_speaker_out,
    output logic [7:0]       plant_delay_out,
    output logic [7:0]       plant_scale_out,
    input  logic             plant_done_in,
    input  sample_t          plant_feedback_in,
    output logic             filt_ready_out,
    output sample_t          filt_error_out,
    input  logic             filt_done_in,
    input  sample_t          filt_output_in,
    output sample_t          speaker_sample_out,
    output logic             sample_valid_out,
    output logic             busy_out,
    output logic [CNT_W-1:0] overrun_count_out,
    output logic             timeout_out
);

    seq_state_t       state_q;
    logic             plant_ready_q;
    logic             filt_ready_q;
    logic             valid_q;
    logic             tmo_q;
    sample_t          amb_q;
    sample_t          err_q;
    sample_t          spk_q;
    logic [7:0]       dly_q;
    logic [7:0]       scl_q;
    logic [7:0]       sh_dly_q;
    logic [7:0]       sh_scl_q;
    logic [CNT_W-1:0] ovr_q;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_tc;

    // The request states sit right before each wait state, so clearing there
    // gives every wait state a fresh count starting at zero.
    assign tmr_clr = (state_q == PLANT_REQ) || (state_q == FILT_REQ);
    assign tmr_en  = (state_q == PLANT_WAIT) || (state_q == FILT_WAIT);

    wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i  (clk_in),
        .rst_ni (reset_in),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .tc_o   (tmr_tc)
    );

    // Shadow configuration: captured whenever requested, regardless of state.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            sh_dly_q <= DELAY_RESET;
            sh_scl_q <= SCALE_RESET;
        end else if (cfg_load_in) begin
            sh_dly_q <= cfg_delay_in;
            sh_scl_q <= cfg_scale_in;
        end
    end

    // Overrun counter: a strobe that lands in any non-idle state is dropped.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            ovr_q <= '0;
        end else if (sample_strobe_in && (state_q != IDLE) && (ovr_q != {CNT_W{1'b1}})) begin
            ovr_q <= ovr_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Sequencer FSM with registered data latches and one-cycle start/valid pulses.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q       <= IDLE;
            plant_ready_q <= 1'b0;
            filt_ready_q  <= 1'b0;
            valid_q       <= 1'b0;
            tmo_q         <= 1'b0;
            amb_q         <= '0;
            err_q         <= '0;
            spk_q         <= '0;
            dly_q         <= DELAY_RESET;
            scl_q         <= SCALE_RESET;
        end else begin
            plant_ready_q <= 1'b0;
            filt_ready_q  <= 1'b0;
            valid_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sample_strobe_in) begin
                        amb_q         <= ambient_sample_in;
                        // A load in the acceptance cycle bypasses the shadow so it applies to this sample.
                        dly_q         <= cfg_load_in ? cfg_delay_in : sh_dly_q;
                        scl_q         <= cfg_load_in ? cfg_scale_in : sh_scl_q;
                        plant_ready_q <= 1'b1;
                        state_q       <= PLANT_REQ;
                    end
                end
                PLANT_REQ: begin
                    state_q <= PLANT_WAIT;
                end
                PLANT_WAIT: begin
                    if (plant_done_in) begin
                        err_q        <= plant_feedback_in;
                        filt_ready_q <= 1'b1;
                        state_q      <= FILT_REQ;
                    end else if (tmr_tc) begin
                        tmo_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                FILT_REQ: begin
                    state_q <= FILT_WAIT;
                end
                FILT_WAIT: begin
                    if (filt_done_in) begin
                        spk_q   <= filt_output_in;
                        valid_q <= 1'b1;
                        state_q <= UPDATE;
                    end else if (tmr_tc) begin
                        tmo_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                UPDATE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign plant_ready_out    = plant_ready_q;
    assign plant_ambient_out  = amb_q;
    // The speaker sample produced last time is what the plant hears now: one-sample loop delay.
    assign plant_speaker_out  = spk_q;
    assign plant_delay_out    = dly_q;
    assign plant_scale_out    = scl_q;
    assign filt_ready_out     = filt_ready_q;
    assign filt_error_out     = err_q;
    assign speaker_sample_out = spk_q;
    assign sample_valid_out   = valid_q;
    assign busy_out           = (state_q != IDLE);
    assign overrun_count_out  = ovr_q;
    assign timeout_out        = tmo_q;

endmodule

// File: tb/tb_anc_sample_sequencer.sv
// Self-checking bench for anc_sample_sequencer.
// The bench plays plant and filter, drives a table of directed samples, then random samples.
// Expected values come from a transaction-level model of one sample at a time.
module tb_anc_sample_sequencer;

    localparam int TMO  = 16;
    localparam int CW   = 6;
    localparam int OMAX = (1 << CW) - 1;

    logic                    clk_in;
    logic                    reset_in;
    logic                    sample_strobe_in;
    logic signed [15:0]      ambient_sample_in;
    logic [7:0]              cfg_delay_in;
    logic [7:0]              cfg_scale_in;
    logic                    cfg_load_in;
    logic                    plant_ready_out;
    logic signed [15:0]      plant_ambient_out;
    logic signed [15:0]      plant_speaker_out;
    logic [7:0]              plant_delay_out;
    logic [7:0]              plant_scale_out;
    logic                    plant_done_in;
    logic signed [15:0]      plant_feedback_in;
    logic                    filt_ready_out;
    logic signed [15:0]      filt_error_out;
    logic                    filt_done_in;
    logic signed [15:0]      filt_output_in;
    logic signed [15:0]      speaker_sample_out;
    logic                    sample_valid_out;
    logic                    busy_out;
    logic [CW-1:0]           overrun_count_out;
    logic                    timeout_out;

    anc_sample_sequencer #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (CW)
    ) dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .sample_strobe_in  (sample_strobe_in),
        .ambient_sample_in (ambient_sample_in),
        .cfg_delay_in      (cfg_delay_in),
        .cfg_scale_in      (cfg_scale_in),
        .cfg_load_in       (cfg_load_in),
        .plant_ready_out   (plant_ready_out),
        .plant_ambient_out (plant_ambient_out),
        .plant_speaker_out (plant_speaker_out),
        .plant_delay_out   (plant_delay_out),
        .plant_scale_out   (plant_scale_out),
        .plant_done_in     (plant_done_in),
        .plant_feedback_in (plant_feedback_in),
        .filt_ready_out    (filt_ready_out),
        .filt_error_out    (filt_error_out),
        .filt_done_in      (filt_done_in),
        .filt_output_in    (filt_output_in),
        .speaker_sample_out(speaker_sample_out),
        .sample_valid_out  (sample_valid_out),
        .busy_out          (busy_out),
        .overrun_count_out (overrun_count_out),
        .timeout_out       (timeout_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Counts every cycle in which the valid pulse was present.
    int valid_seen = 0;
    always @(posedge clk_in) if (sample_valid_out === 1'b1) valid_seen++;

    // Transaction-level model of what the block should be showing.
    int exp_spk, exp_err, exp_ovr, exp_tmo, exp_valid;
    int sh_dly, sh_scl, act_dly, act_scl;

    // One sample as seen from outside: plant/filter response times (0 = never answers).
    typedef struct {
        int amb; int pd; int fb; int fd; int fo;
        int ex; int upd;
        int ln; int ld_d; int ld_s;
        int lm; int md_d; int md_s;
        int e_spk; int e_ovr; int e_tmo;
    } vec_t;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    function automatic int sat_inc(input int v);
        return (v < OMAX) ? v + 1 : OMAX;
    endfunction

    task automatic model_reset();
        exp_spk = 0; exp_err = 0; exp_ovr = 0; exp_tmo = 0;
        sh_dly = 64; sh_scl = 128; act_dly = 64; act_scl = 128;
    endtask

    task automatic clear_inputs();
        sample_strobe_in = 1'b0; cfg_load_in = 1'b0;
        plant_done_in = 1'b0; filt_done_in = 1'b0;
    endtask

    task automatic run_sample(input vec_t v);
        // Idle cycle with spurious done pulses that must be ignored.
        plant_done_in = 1'b1; plant_feedback_in = 16'($urandom);
        filt_done_in = 1'b1; filt_output_in = 16'($urandom);
        step();
        clear_inputs();
        chk("idle_busy", busy_out, 0);
        chk("idle_pready", plant_ready_out, 0);
        chk("idle_err", filt_error_out, exp_err);
        chk("idle_spk", speaker_sample_out, exp_spk);

        // Strobe acceptance, optionally with a same-cycle config load.
        sample_strobe_in = 1'b1; ambient_sample_in = 16'(v.amb);
        if (v.ln != 0) begin
            cfg_load_in = 1'b1; cfg_delay_in = 8'(v.ld_d); cfg_scale_in = 8'(v.ld_s);
            sh_dly = v.ld_d; sh_scl = v.ld_s;
        end
        act_dly = sh_dly; act_scl = sh_scl;
        step();
        clear_inputs();
        chk("req_pready", plant_ready_out, 1);
        chk("req_busy", busy_out, 1);
        chk("req_amb", plant_ambient_out, v.amb);
        chk("req_pspk", plant_speaker_out, exp_spk);
        chk("req_dly", plant_delay_out, act_dly);
        chk("req_scl", plant_scale_out, act_scl);
        step();
        chk("wait_pready", plant_ready_out, 0);

        if (v.pd == 0) begin
            for (int i = 1; i <= TMO; i++) begin
                sample_strobe_in = (i <= v.ex);
                filt_done_in = i[0]; filt_output_in = 16'($urandom);
                if (i <= v.ex) exp_ovr = sat_inc(exp_ovr);
                step();
                clear_inputs();
                if (i == TMO - 1) chk("ptmo_still_busy", busy_out, 1);
            end
            exp_tmo = 1;
            chk("ptmo_idle", busy_out, 0);
        end else begin
            for (int i = 1; i <= v.pd; i++) begin
                sample_strobe_in = (i <= v.ex);
                plant_done_in = (i == v.pd);
                plant_feedback_in = (i == v.pd) ? 16'(v.fb) : 16'($urandom);
                filt_done_in = (i < v.pd); filt_output_in = 16'($urandom);
                if (i <= v.ex) exp_ovr = sat_inc(exp_ovr);
                step();
                clear_inputs();
            end
            exp_err = v.fb;
            chk("freq_fready", filt_ready_out, 1);
            chk("freq_err", filt_error_out, exp_err);
            chk("freq_busy", busy_out, 1);
            plant_done_in = 1'b1; plant_feedback_in = 16'($urandom);
            step();
            clear_inputs();
            chk("fwait_fready", filt_ready_out, 0);

            if (v.fd == 0) begin
                for (int i = 1; i <= TMO; i++) begin
                    if (i == 1 && v.lm != 0) begin
                        cfg_load_in = 1'b1; cfg_delay_in = 8'(v.md_d); cfg_scale_in = 8'(v.md_s);
                        sh_dly = v.md_d; sh_scl = v.md_s;
                    end
                    plant_done_in = i[0]; plant_feedback_in = 16'($urandom);
                    step();
                    clear_inputs();
                    if (i == TMO - 1) chk("ftmo_still_busy", busy_out, 1);
                end
                exp_tmo = 1;
                chk("ftmo_idle", busy_out, 0);
                chk("ftmo_err", filt_error_out, exp_err);
            end else begin
                for (int i = 1; i <= v.fd; i++) begin
                    if (i == 1 && v.lm != 0) begin
                        cfg_load_in = 1'b1; cfg_delay_in = 8'(v.md_d); cfg_scale_in = 8'(v.md_s);
                        sh_dly = v.md_d; sh_scl = v.md_s;
                    end
                    filt_done_in = (i == v.fd);
                    filt_output_in = (i == v.fd) ? 16'(v.fo) : 16'($urandom);
                    plant_done_in = (i < v.fd); plant_feedback_in = 16'($urandom);
                    step();
                    clear_inputs();
                end
                exp_spk = v.fo;
                exp_valid++;
                chk("upd_valid", sample_valid_out, 1);
                chk("upd_spk", speaker_sample_out, exp_spk);
                chk("upd_err", filt_error_out, exp_err);
                chk("upd_dly_held", plant_delay_out, act_dly);
                chk("upd_scl_held", plant_scale_out, act_scl);
                sample_strobe_in = (v.upd != 0);
                if (v.upd != 0) exp_ovr = sat_inc(exp_ovr);
                step();
                clear_inputs();
                chk("end_busy", busy_out, 0);
                chk("end_valid", sample_valid_out, 0);
            end
        end
        chk("end_ovr", overrun_count_out, exp_ovr);
        chk("end_tmo", timeout_out, exp_tmo);
        chk("end_spk", speaker_sample_out, exp_spk);
        chk("end_vcount", valid_seen, exp_valid);
    endtask

    vec_t tbl[11];
    vec_t rv;

    initial begin
        //        amb   pd  fb     fd  fo     ex  upd ln ld_d ld_s lm md_d md_s  e_spk  e_ovr e_tmo
        tbl[0]  = '{1000,  3, -200,  2, -950,   0, 0,  0, 0,   0,   0, 0,  0,   -950,  0,  0};
        tbl[1]  = '{-500,  5,   77,  1, 1234,   3, 1,  0, 0,   0,   1, 10, 64,  1234,  4,  0};
        tbl[2]  = '{32767, 1, -32768, 1, 32767, 0, 0,  0, 0,   0,   0, 0,  0,   32767, 4,  0};
        tbl[3]  = '{5,     0,    0,  0,    0,   0, 0,  0, 0,   0,   0, 0,  0,   32767, 4,  1};
        tbl[4]  = '{-1,    2,    3,  4, -32768, 0, 0,  1, 200, 7,   0, 0,  0,  -32768, 4,  1};
        tbl[5]  = '{9,     6,  -11,  0,    0,   6, 0,  0, 0,   0,   0, 0,  0,  -32768, 10, 1};
        tbl[6]  = '{10,    0,    0,  0,    0,  16, 0,  0, 0,   0,   0, 0,  0,  -32768, 26, 1};
        tbl[7]  = '{11,    0,    0,  0,    0,  16, 0,  0, 0,   0,   0, 0,  0,  -32768, 42, 1};
        tbl[8]  = '{12,    0,    0,  0,    0,  16, 0,  0, 0,   0,   0, 0,  0,  -32768, 58, 1};
        tbl[9]  = '{13,   16,  500, 16,   42,  16, 1,  0, 0,   0,   0, 0,  0,   42,   63,  1};
        tbl[10] = '{14,    4,   -8,  1,   -7,   2, 1,  0, 0,   0,   0, 0,  0,   -7,   63,  1};

        clear_inputs();
        ambient_sample_in = '0; cfg_delay_in = '0; cfg_scale_in = '0;
        plant_feedback_in = '0; filt_output_in = '0;
        exp_valid = 0;
        model_reset();
        reset_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_busy", busy_out, 0);
        chk("rst_spk", speaker_sample_out, 0);
        chk("rst_dly", plant_delay_out, 64);
        chk("rst_scl", plant_scale_out, 128);
        chk("rst_ovr", overrun_count_out, 0);
        chk("rst_tmo", timeout_out, 0);
        reset_in = 1'b1;
        step();

        // Directed table.
        for (int k = 0; k < 11; k++) begin
            run_sample(tbl[k]);
            chk("tbl_spk", speaker_sample_out, tbl[k].e_spk);
            chk("tbl_ovr", overrun_count_out, tbl[k].e_ovr);
            chk("tbl_tmo", timeout_out, tbl[k].e_tmo);
        end

        // Async reset in the middle of the filter wait.
        sample_strobe_in = 1'b1; ambient_sample_in = 16'sd111;
        step();
        clear_inputs();
        step();
        plant_done_in = 1'b1; plant_feedback_in = 16'sd55;
        step();
        clear_inputs();
        step();
        chk("pre_rst_err", filt_error_out, 55);
        chk("pre_rst_busy", busy_out, 1);
        #2 reset_in = 1'b0;
        #1;
        chk("arst_busy", busy_out, 0);
        chk("arst_spk", speaker_sample_out, 0);
        chk("arst_pspk", plant_speaker_out, 0);
        chk("arst_amb", plant_ambient_out, 0);
        chk("arst_err", filt_error_out, 0);
        chk("arst_dly", plant_delay_out, 64);
        chk("arst_scl", plant_scale_out, 128);
        chk("arst_ovr", overrun_count_out, 0);
        chk("arst_tmo", timeout_out, 0);
        chk("arst_pulses", {plant_ready_out, filt_ready_out, sample_valid_out}, 0);
        @(negedge clk_in);
        reset_in = 1'b1;
        model_reset();
        run_sample(tbl[0]);
        chk("post_rst_spk", speaker_sample_out, -950);

        // Randomized samples against the model.
        for (int k = 0; k < 40; k++) begin
            rv.amb = int'($signed(16'($urandom)));
            rv.pd  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
            rv.fd  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
            rv.fb  = int'($signed(16'($urandom)));
            rv.fo  = int'($signed(16'($urandom)));
            rv.ex  = (rv.pd == 0) ? int'($urandom_range(0, TMO)) : int'($urandom_range(0, rv.pd));
            rv.upd = int'($urandom_range(0, 1));
            rv.ln  = int'($urandom_range(0, 1));
            rv.ld_d = int'($urandom_range(0, 255));
            rv.ld_s = int'($urandom_range(0, 255));
            rv.lm  = int'($urandom_range(0, 1));
            rv.md_d = int'($urandom_range(0, 255));
            rv.md_s = int'($urandom_range(0, 255));
            rv.e_spk = 0; rv.e_ovr = 0; rv.e_tmo = 0;
            run_sample(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/anc_sample_sequencer.md
Name: anc_sample_sequencer

Overview:
Per-sample controller for the ANC loop. On each audio sample strobe it:
- hands the ambient sample and the current speaker sample to the cup plant model (delay/scale datapath);
- waits for the plant's done;
- passes the resulting feedback (error) sample to the cancellation filter;
- registers the filter output as the next speaker sample.
It also owns the plant delay/scale configuration, applied only at sample boundaries, plus overrun and timeout supervision.

Parameters:
DELAY_RESET, 8'd64, plant delay value after reset
SCALE_RESET, 8'd128, plant scale value after reset
TIMEOUT_CYCLES, 1024, max clk cycles spent in either wait state before abort (>=2)
CNT_W, 16, width of overrun counter

Ports:
clk_in  in  1  system clock
reset_in  in  1  asynchronous, active-low reset
sample_strobe_in  in  1  one-cycle pulse per audio sample
ambient_sample_in  in  16 signed  ambient mic sample, valid with strobe
cfg_delay_in  in  8  requested plant delay
cfg_scale_in  in  8  requested plant scale
cfg_load_in  in  1  capture cfg_* into shadow registers
plant_ready_out  out  1  one-cycle start pulse to plant
plant_ambient_out  out  16 signed  latched ambient sample
plant_speaker_out  out  16 signed  current speaker sample fed to plant
plant_delay_out  out  8  active delay
plant_scale_out  out  8  active scale
plant_done_in  in  1  plant finished
plant_feedback_in  in  16 signed  plant feedback sample, valid with done
filt_ready_out  out  1  one-cycle start pulse to filter
filt_error_out  out  16 signed  latched feedback sample
filt_done_in  in  1  filter finished
filt_output_in  in  16 signed  filter output, valid with done
speaker_sample_out  out  16 signed  registered speaker sample
sample_valid_out  out  1  one-cycle pulse: speaker_sample_out updated
busy_out  out  1  high in every state except IDLE
overrun_count_out  out  CNT_W  strobes dropped while busy, saturating
timeout_out  out  1  sticky: a wait state timed out

Behaviour:
- Reset (async assert, sync deassert by design convention):
  - State IDLE.
  - All 16-bit data outputs 0, all pulses 0, counters 0, timeout_out 0.
  - Active and shadow delay = DELAY_RESET, scale = SCALE_RESET.
  - Reset mid-operation aborts immediately; no pending pulse survives.
- States: IDLE, PLANT_REQ, PLANT_WAIT, FILT_REQ, FILT_WAIT, UPDATE.
- IDLE + strobe at edge T:
  - Latch ambient_sample_in into plant_ambient_out.
  - Copy shadow cfg to plant_delay_out/plant_scale_out.
  - Go to PLANT_REQ.
- PLANT_REQ (cycle T+1): plant_ready_out=1 for exactly this cycle; go to PLANT_WAIT.
- PLANT_WAIT:
  - Wait counter starts at 0.
  - On plant_done_in: latch plant_feedback_in into filt_error_out, go to FILT_REQ.
- FILT_REQ: filt_ready_out=1 for one cycle; go to FILT_WAIT.
- FILT_WAIT: on filt_done_in, latch filt_output_in into speaker_sample_out, go to UPDATE.
- UPDATE: sample_valid_out=1 for one cycle; go to IDLE.
- Latency: if both done inputs arrive on the first wait cycle, strobe at T gives sample_valid_out at T+5 and IDLE at T+6.
- Done inputs are ignored outside their own wait state (no queuing).
- Timeout:
  - Wait counter resets on entry to each wait state.
  - If it reaches TIMEOUT_CYCLES-1 without done: set timeout_out and return to IDLE.
  - speaker_sample_out holds its previous value; no sample_valid_out pulse.
- Overrun:
  - Strobe while busy (any non-IDLE state, including UPDATE) is dropped.
  - overrun_count_out increments and saturates at all-ones.
- Config:
  - cfg_load_in captures shadow registers in any state.
  - Active outputs change only at strobe acceptance.
  - cfg_load_in and an accepted strobe in the same cycle: the new values apply to this sample.
- plant_speaker_out = speaker_sample_out, giving a one-sample loop delay; the plant sums it internally.
- No arithmetic in this block; all samples pass through unmodified at 16-bit signed width.

Decomposition:
- Shared package anc_pkg:
  - typedef sample_t (logic signed [15:0]);
  - seq_state_t enum;
  - DEFAULT_DELAY/DEFAULT_SCALE constants, reused by the cup plant model.
- One sub-module: wait_timer (load/clear, enable, terminal-count flag, parameter TIMEOUT_CYCLES), instantiated once and shared by both wait states.

Test Plan:
1. Nominal sample:
   - Stimulus: strobe with ambient=16'sd1000; plant done 3 cycles after its ready, feedback=-200; filter done 2 cycles after its ready, output=-950.
   - Response: plant_ready at T+1, filt_error=-200, speaker=-950 with sample_valid pulse; next sample has plant_speaker_out=-950.
2. Config timing:
   - Stimulus: cfg_load delay=10, scale=64 while in FILT_WAIT.
   - Response: plant_delay_out stays 64 and plant_scale_out stays 128 until the next strobe, then become 10/64. Same-cycle load+strobe in IDLE applies immediately.
3. Overrun:
   - Stimulus: 3 strobes during PLANT_WAIT and 1 in the UPDATE cycle.
   - Response: overrun_count=4, sample unaffected. Preloading near saturation, count sticks at 16'hFFFF.
4. Timeout:
   - Stimulus: TIMEOUT_CYCLES=16, plant never done.
   - Response: IDLE after 16 wait cycles, timeout_out=1, no sample_valid, speaker unchanged. Next sample completes normally and timeout stays 1.
5. Spurious done:
   - Stimulus: plant_done in IDLE or FILT_WAIT, filt_done in PLANT_WAIT.
   - Response: ignored, no state change.
6. Async reset:
   - Stimulus: reset_in low mid-FILT_WAIT.
   - Response: all outputs 0 or reset values immediately without a clock edge. After release, first strobe behaves as in scenario 1.
